phase_timer: RTL and testbench

Registered phase stage directly downstream of the pedestrian/lane mode logic. When the sequencer strobes `load`, the block captures the selected mode's lane and walking-light patterns and its 7-bit `loadTime`, and drives those patterns to the lights. It counts the phase duration in seconds and pulses `done` when the phase expires so the sequencer can select the next mode.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/phase_timer.sv | 104 ++++++++++
 tb/tb_phase_timer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and widths for the traffic-light phase datapath.
// Used by phase_timer and its prescaler.
package traffic_pkg;

    localparam int LANE_W = 8;
    localparam int TIME_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } phase_state_t;

    typedef logic [0:LANE_W-1] lane_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// clr restarts the count; en low freezes it in place.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Registered light-pattern phase with a seconds countdown and done pulse.
// Optional PHASE_TIMER_HOLD_EN adds a hold input that freezes the countdown.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int WARN_SECS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [TIME_W-1:0] load_time,
    input  lane_t             lane_in,
    input  lane_t             walk_in,
`ifdef PHASE_TIMER_HOLD_EN
    input  logic              hold,
`endif
    output lane_t             lane_out,
    output lane_t             walk_out,
    output logic [TIME_W-1:0] remaining,
    output logic              busy,
    output logic              done,
    output logic              warn
);

    phase_state_t      state_q;
    lane_t             lane_q, walk_q;
    logic [TIME_W-1:0] rem_q;
    logic              busy_q, done_q;
    logic              zdone_q;
    logic              tick, tick_en;

`ifdef PHASE_TIMER_HOLD_EN
    assign tick_en = ~hold;
`else
    assign tick_en = 1'b1;
`endif

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (load),
        .en   (tick_en),
        .tick (tick)
    );

    // zdone_q delays the zero-time done by one cycle so it lands after N+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
            walk_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            zdone_q <= 1'b0;
            if (load) begin
                lane_q <= lane_in;
                walk_q <= walk_in;
                rem_q  <= load_time;
                if (load_time != '0) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    zdone_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    RUN: begin
                        if (tick) begin
                            rem_q <= rem_q - TIME_W'(1);
                            if (rem_q == TIME_W'(1)) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    IDLE: begin
                        if (zdone_q) begin
                            done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lane_out  = lane_q;
    assign walk_out  = walk_q;
    assign remaining = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign warn      = busy_q && (rem_q <= TIME_W'(WARN_SECS));

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer with TICK_DIV=4, WARN_SECS=3.
// Define PHASE_TIMER_HOLD_EN to also exercise the hold input.
module tb_phase_timer;
    import traffic_pkg::*;

    localparam int TD = 4;

    typedef struct {
        int         cyc;
        logic [6:0] rem;
        logic       busy;
        logic       done;
        logic       warn;
        lane_t      lane;
        lane_t      walk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_time = '0;
    lane_t      lane_in = '0;
    lane_t      walk_in = '0;
    logic       hold = 1'b0;
    lane_t      lane_out, walk_out;
    logic [6:0] remaining;
    logic       busy, done, warn;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   done_q[$];

    phase_timer #(
        .TICK_DIV (TD),
        .WARN_SECS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_time(load_time),
        .lane_in  (lane_in),
        .walk_in  (walk_in),
`ifdef PHASE_TIMER_HOLD_EN
        .hold     (hold),
`endif
        .lane_out (lane_out),
        .walk_out (walk_out),
        .remaining(remaining),
        .busy     (busy),
        .done     (done),
        .warn     (warn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL state@%0d: entry not reached (now %0d)",
                         e.cyc, cyc);
            end else if (remaining !== e.rem || busy !== e.busy ||
                         done !== e.done || warn !== e.warn ||
                         lane_out !== e.lane || walk_out !== e.walk) begin
                errors++;
                $display({"FAIL state@%0d: got rem=%0d busy=%b done=%b ",
                          "warn=%b lane=%h walk=%h, want rem=%0d busy=%b ",
                          "done=%b warn=%b lane=%h walk=%h"},
                         cyc, remaining, busy, done, warn, lane_out,
                         walk_out, e.rem, e.busy, e.done, e.warn,
                         e.lane, e.walk);
            end
        end
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL done_pulse: got none at %0d, want pulse",
                     done_q.pop_front());
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
            end else begin
                errors++;
                $display("FAIL done_pulse: got pulse at %0d, want none",
                         cyc);
            end
        end
    end

    task automatic push_zero(input int first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{cyc: first + i, rem: 7'd0, busy: 1'b0, done: 1'b0,
                  warn: 1'b0, lane: '0, walk: '0};
            exp_q.push_back(e);
        end
    endtask

    // Expected trace of a phase loaded at edge n, for ncyc cycles.
    task automatic push_phase(input int n, input int t, input lane_t ln,
                              input lane_t wk, input int ncyc);
        exp_t e;
        int   k;
        for (int i = 0; i < ncyc; i++) begin
            k = i / TD;
            e.cyc  = n + i;
            e.rem  = (k >= t) ? 7'd0 : 7'(t - k);
            e.busy = (i < TD * t);
            e.done = (t == 0) ? (i == 1) : (i == TD * t);
            e.warn = e.busy && (e.rem <= 7'd3);
            e.lane = ln;
            e.walk = wk;
            exp_q.push_back(e);
        end
        if (t == 0 && ncyc > 1) done_q.push_back(n + 1);
        if (t != 0 && TD * t < ncyc) done_q.push_back(n + TD * t);
    endtask

    // Call at a negedge; returns at the negedge after the load edge.
    task automatic do_load(input int t, input lane_t ln, input lane_t wk,
                           input int ncyc, output int n);
        n = cyc + 1;
        push_phase(n, t, ln, wk, ncyc);
        load      = 1'b1;
        load_time = 7'(t);
        lane_in   = ln;
        walk_in   = wk;
        @(negedge clk);
        load      = 1'b0;
        lane_in   = 8'h5A;
        walk_in   = 8'hC3;
        load_time = 7'd9;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   n, n2;
        exp_t e;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_zero(cyc, 21);
        repeat (20) @(negedge clk);

        do_load(12, 8'h00, 8'hFF, 52, n);
        repeat (52) @(negedge clk);

        do_load(0, 8'hA5, 8'h3C, 4, n);
        repeat (4) @(negedge clk);

        do_load(5, 8'h81, 8'h18, 20, n);
        repeat (19) @(negedge clk);
        do_load(7, 8'h42, 8'h24, 31, n2);
        repeat (31) @(negedge clk);

        do_load(6, 8'h11, 8'h22, 9, n);
        repeat (8) @(negedge clk);
        push_zero(n + 9, 22);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (22) @(negedge clk);

`ifdef PHASE_TIMER_HOLD_EN
        do_load(3, 8'h0F, 8'hF0, 2, n);
        e = '{cyc: n + 11, rem: 7'd3, busy: 1'b1, done: 1'b0,
              warn: 1'b1, lane: 8'h0F, walk: 8'hF0};
        exp_q.push_back(e);
        e.cyc = n + 14;
        e.rem = 7'd2;
        exp_q.push_back(e);
        e = '{cyc: n + 22, rem: 7'd0, busy: 1'b0, done: 1'b1,
              warn: 1'b0, lane: 8'h0F, walk: 8'hF0};
        exp_q.push_back(e);
        done_q.push_back(n + 22);
        @(negedge clk);
        hold = 1'b1;
        repeat (10) @(negedge clk);
        hold = 1'b0;
        repeat (14) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     exp_q.size(), done_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
